// File: rtl/regset_n.sv
// Parametrised register file with write, inc/dec and pending-load scoreboard.
// Define REGSET_BYPASS_EN to forward same-cycle write data to the read ports.
module regset_n #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_wrEn,
  input  logic [AW-1:0]    i_wrSel,
  input  logic             i_incEn,
  input  logic             i_dec,
  input  logic [AW-1:0]    i_incSel,
  input  logic             i_lockEn,
  input  logic [AW-1:0]    i_lockSel,
  input  logic [AW-1:0]    i_busSel,
  input  logic             i_busEn,
  output logic [WIDTH-1:0] o_bus,
  output logic             o_busStall,
  input  logic [AW-1:0]    i_aluSel,
  output logic [WIDTH-1:0] o_alu,
  output logic             o_aluStall,
  output logic             o_wrap
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;
  logic             wrap_q, wrap_d;
  logic             incApplied;
  logic             aluHit, busHit, aluLockHit, busLockHit;

  // A write to the same register cancels the inc/dec, including its wrap flag.
  assign incApplied = i_incEn && !(i_wrEn && (i_wrSel == i_incSel));

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    wrap_d = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_wrEn && (i_wrSel == AW'(i))) begin
        regs_d[i] = i_d;
        pend_d[i] = 1'b0;
      end else if (i_incEn && (i_incSel == AW'(i))) begin
        regs_d[i] = i_dec ? regs_q[i] - WIDTH'(1) : regs_q[i] + WIDTH'(1);
      end
      if (i_lockEn && (i_lockSel == AW'(i))) begin
        pend_d[i] = 1'b1;
      end
    end
    if (incApplied) begin
      wrap_d = i_dec ? (regs_q[i_incSel] == '0) : (regs_q[i_incSel] == '1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      wrap_q <= wrap_d;
    end
  end

  assign aluLockHit = i_lockEn && (i_lockSel == i_aluSel);
  assign busLockHit = i_lockEn && (i_lockSel == i_busSel);

`ifdef REGSET_BYPASS_EN
  assign aluHit = !i_reset && i_wrEn && (i_wrSel == i_aluSel);
  assign busHit = !i_reset && i_wrEn && i_busEn && (i_wrSel == i_busSel);
`else
  assign aluHit = 1'b0;
  assign busHit = 1'b0;
`endif

  // Forwarded data clears the stall unless a new load is issued on that register.
  always_comb begin
    o_alu      = aluHit ? i_d : regs_q[i_aluSel];
    o_aluStall = pend_q[i_aluSel] && !(aluHit && !aluLockHit);
    o_bus      = '0;
    o_busStall = 1'b0;
    if (i_busEn) begin
      o_bus      = busHit ? i_d : regs_q[i_busSel];
      o_busStall = pend_q[i_busSel] && !(busHit && !busLockHit);
    end
  end

  assign o_wrap = wrap_q;

endmodule

// File: tb/tb_regset_n.sv
// Directed self-checking bench for regset_n (WIDTH=8, DEPTH=4).
// Expectations adapt to REGSET_BYPASS_EN when it is defined.
module tb_regset_n;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic [7:0] i_d;
  logic       i_wrEn;
  logic [1:0] i_wrSel;
  logic       i_incEn;
  logic       i_dec;
  logic [1:0] i_incSel;
  logic       i_lockEn;
  logic [1:0] i_lockSel;
  logic [1:0] i_busSel;
  logic       i_busEn;
  logic [7:0] o_bus;
  logic       o_busStall;
  logic [1:0] i_aluSel;
  logic [7:0] o_alu;
  logic       o_aluStall;
  logic       o_wrap;

  int passCount = 0;
  int checkCount = 0;

`ifdef REGSET_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  regset_n #(.WIDTH(8), .DEPTH(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_d(i_d),
    .i_wrEn(i_wrEn), .i_wrSel(i_wrSel),
    .i_incEn(i_incEn), .i_dec(i_dec), .i_incSel(i_incSel),
    .i_lockEn(i_lockEn), .i_lockSel(i_lockSel),
    .i_busSel(i_busSel), .i_busEn(i_busEn),
    .o_bus(o_bus), .o_busStall(o_busStall),
    .i_aluSel(i_aluSel), .o_alu(o_alu), .o_aluStall(o_aluStall),
    .o_wrap(o_wrap)
  );

  always #5 i_clk = ~i_clk;

  // Inputs change 1ns after the rising edge; checks land mid-cycle.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idleInputs();
    i_d = 8'h00; i_wrEn = 1'b0; i_wrSel = 2'd0;
    i_incEn = 1'b0; i_dec = 1'b0; i_incSel = 2'd0;
    i_lockEn = 1'b0; i_lockSel = 2'd0;
  endtask

  task automatic test_reset();
    idleInputs();
    i_aluSel = 2'd2; i_busSel = 2'd2; i_busEn = 1'b1;
    tick();
    i_wrEn = 1'b1; i_wrSel = 2'd2; i_d = 8'h5A;
    i_lockEn = 1'b1; i_lockSel = 2'd2;
    #2 i_reset = 1'b1;
    #1;
    checkCount++;
    if (o_alu !== 8'h00) $display("[TB] FAIL rst_alu: got %h expected 00", o_alu); else passCount++;
    checkCount++;
    if (o_bus !== 8'h00) $display("[TB] FAIL rst_bus: got %h expected 00", o_bus); else passCount++;
    checkCount++;
    if (o_aluStall !== 1'b0 || o_busStall !== 1'b0)
      $display("[TB] FAIL rst_stall: got %b%b expected 00", o_aluStall, o_busStall);
    else passCount++;
    checkCount++;
    if (o_wrap !== 1'b0) $display("[TB] FAIL rst_wrap: got %b expected 0", o_wrap); else passCount++;
    tick();
    tick();
    i_reset = 1'b0;
    idleInputs();
    #1;
    checkCount++;
    if (o_alu !== 8'h00 || o_aluStall !== 1'b0)
      $display("[TB] FAIL rst_release: got %h/%b expected 00/0", o_alu, o_aluStall);
    else passCount++;
    i_wrEn = 1'b1; i_wrSel = 2'd2; i_d = 8'h5A;
    tick();
    i_wrSel = 2'd3; i_d = 8'hC3;
    tick();
    idleInputs();
    i_aluSel = 2'd2; i_busSel = 2'd3; i_busEn = 1'b1;
    #1;
    checkCount++;
    if (o_alu !== 8'h5A) $display("[TB] FAIL read_alu_r2: got %h expected 5A", o_alu); else passCount++;
    checkCount++;
    if (o_bus !== 8'hC3) $display("[TB] FAIL read_bus_r3: got %h expected C3", o_bus); else passCount++;
    i_busEn = 1'b0;
    #1;
    checkCount++;
    if (o_bus !== 8'h00) $display("[TB] FAIL read_bus_off: got %h expected 00", o_bus); else passCount++;
  endtask

  task automatic test_wrap();
    i_wrEn = 1'b1; i_wrSel = 2'd1; i_d = 8'hFF;
    tick();
    idleInputs();
    i_incEn = 1'b1; i_incSel = 2'd1; i_dec = 1'b0;
    tick();
    idleInputs();
    i_aluSel = 2'd1;
    #1;
    checkCount++;
    if (o_alu !== 8'h00) $display("[TB] FAIL inc_wrap_val: got %h expected 00", o_alu); else passCount++;
    checkCount++;
    if (o_wrap !== 1'b1) $display("[TB] FAIL inc_wrap_pulse: got %b expected 1", o_wrap); else passCount++;
    tick();
    checkCount++;
    if (o_wrap !== 1'b0) $display("[TB] FAIL inc_wrap_clear: got %b expected 0", o_wrap); else passCount++;
    i_incEn = 1'b1; i_incSel = 2'd1; i_dec = 1'b1;
    tick();
    idleInputs();
    #1;
    checkCount++;
    if (o_alu !== 8'hFF) $display("[TB] FAIL dec_wrap_val: got %h expected FF", o_alu); else passCount++;
    checkCount++;
    if (o_wrap !== 1'b1) $display("[TB] FAIL dec_wrap_pulse: got %b expected 1", o_wrap); else passCount++;
    tick();
    checkCount++;
    if (o_wrap !== 1'b0) $display("[TB] FAIL dec_wrap_clear: got %b expected 0", o_wrap); else passCount++;
    i_incEn = 1'b1; i_incSel = 2'd2; i_dec = 1'b0;
    tick();
    idleInputs();
    i_aluSel = 2'd2;
    #1;
    checkCount++;
    if (o_alu !== 8'h5B || o_wrap !== 1'b0)
      $display("[TB] FAIL inc_plain: got %h/%b expected 5B/0", o_alu, o_wrap);
    else passCount++;
  endtask

  task automatic test_collision();
    i_wrEn = 1'b1; i_wrSel = 2'd0; i_d = 8'hFF;
    tick();
    i_d = 8'h10;
    i_incEn = 1'b1; i_incSel = 2'd0; i_dec = 1'b0;
    tick();
    idleInputs();
    i_aluSel = 2'd0;
    #1;
    checkCount++;
    if (o_alu !== 8'h10) $display("[TB] FAIL collide_val: got %h expected 10", o_alu); else passCount++;
    checkCount++;
    if (o_wrap !== 1'b0) $display("[TB] FAIL collide_wrap: got %b expected 0", o_wrap); else passCount++;
  endtask

  task automatic test_scoreboard();
    i_lockEn = 1'b1; i_lockSel = 2'd3;
    tick();
    idleInputs();
    i_aluSel = 2'd3; i_busSel = 2'd3; i_busEn = 1'b1;
    #1;
    checkCount++;
    if (o_aluStall !== 1'b1) $display("[TB] FAIL lock_alu_stall: got %b expected 1", o_aluStall); else passCount++;
    checkCount++;
    if (o_busStall !== 1'b1) $display("[TB] FAIL lock_bus_stall: got %b expected 1", o_busStall); else passCount++;
    i_busEn = 1'b0;
    #1;
    checkCount++;
    if (o_busStall !== 1'b0) $display("[TB] FAIL bus_stall_off: got %b expected 0", o_busStall); else passCount++;
    i_busEn = 1'b1;
    i_wrEn = 1'b1; i_wrSel = 2'd3; i_d = 8'h77;
    #1;
    checkCount++;
    if (o_aluStall !== !BYPASS) $display("[TB] FAIL wr_stall_same: got %b expected %b", o_aluStall, !BYPASS); else passCount++;
    checkCount++;
    if (o_alu !== (BYPASS ? 8'h77 : 8'hC3))
      $display("[TB] FAIL wr_alu_same: got %h expected %h", o_alu, BYPASS ? 8'h77 : 8'hC3);
    else passCount++;
    tick();
    idleInputs();
    #1;
    checkCount++;
    if (o_aluStall !== 1'b0 || o_busStall !== 1'b0)
      $display("[TB] FAIL wr_stall_next: got %b%b expected 00", o_aluStall, o_busStall);
    else passCount++;
    checkCount++;
    if (o_alu !== 8'h77) $display("[TB] FAIL wr_alu_next: got %h expected 77", o_alu); else passCount++;
    i_lockEn = 1'b1; i_lockSel = 2'd3;
    i_wrEn = 1'b1; i_wrSel = 2'd3; i_d = 8'h42;
    tick();
    idleInputs();
    #1;
    checkCount++;
    if (o_aluStall !== 1'b1) $display("[TB] FAIL lockwr_stall: got %b expected 1", o_aluStall); else passCount++;
    checkCount++;
    if (o_alu !== 8'h42) $display("[TB] FAIL lockwr_val: got %h expected 42", o_alu); else passCount++;
    i_busEn = 1'b0;
  endtask

  task automatic test_bypass();
    i_wrEn = 1'b1; i_wrSel = 2'd0; i_d = 8'h00;
    tick();
    i_d = 8'h99;
    i_aluSel = 2'd0; i_busSel = 2'd0; i_busEn = 1'b1;
    #1;
    checkCount++;
    if (o_alu !== (BYPASS ? 8'h99 : 8'h00))
      $display("[TB] FAIL byp_alu: got %h expected %h", o_alu, BYPASS ? 8'h99 : 8'h00);
    else passCount++;
    checkCount++;
    if (o_bus !== (BYPASS ? 8'h99 : 8'h00))
      $display("[TB] FAIL byp_bus: got %h expected %h", o_bus, BYPASS ? 8'h99 : 8'h00);
    else passCount++;
    i_busEn = 1'b0;
    #1;
    checkCount++;
    if (o_bus !== 8'h00) $display("[TB] FAIL byp_bus_off: got %h expected 00", o_bus); else passCount++;
    tick();
    idleInputs();
    #1;
    checkCount++;
    if (o_alu !== 8'h99) $display("[TB] FAIL byp_next: got %h expected 99", o_alu); else passCount++;
  endtask

  task automatic test_reset_mid();
    i_wrEn = 1'b1; i_wrSel = 2'd2; i_d = 8'hFF;
    tick();
    idleInputs();
    i_lockEn = 1'b1; i_lockSel = 2'd1;
    i_incEn = 1'b1; i_incSel = 2'd2; i_dec = 1'b0;
    #2 i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    idleInputs();
    i_aluSel = 2'd1;
    #1;
    checkCount++;
    if (o_aluStall !== 1'b0) $display("[TB] FAIL mid_lock_lost: got %b expected 0", o_aluStall); else passCount++;
    i_aluSel = 2'd2;
    #1;
    checkCount++;
    if (o_alu !== 8'h00) $display("[TB] FAIL mid_r2: got %h expected 00", o_alu); else passCount++;
    tick();
    checkCount++;
    if (o_wrap !== 1'b0) $display("[TB] FAIL mid_wrap: got %b expected 0", o_wrap); else passCount++;
  endtask

  initial begin
    idleInputs();
    i_busSel = 2'd0; i_busEn = 1'b0; i_aluSel = 2'd0;
    test_reset();
    test_wrap();
    test_collision();
    test_scoreboard();
    test_bypass();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
